// File: rtl/tdc_pkg.sv
// Shared types for the TDC batch statistics engine.
// Holds the accumulator state encoding and readout word indices.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    DONE
  } tdc_acc_state_t;

  localparam logic [2:0] RD_MEAN   = 3'd0;
  localparam logic [2:0] RD_SUM_LO = 3'd1;
  localparam logic [2:0] RD_SUM_HI = 3'd2;
  localparam logic [2:0] RD_MIN    = 3'd3;
  localparam logic [2:0] RD_MAX    = 3'd4;
  localparam logic [2:0] RD_WORDS  = 3'd5;

endpackage

// File: rtl/tdc_hw_accum_if.sv
// Host-side control and byte-wide readout bundle.
// master: host (start, log2_n, rd_next out); slave: engine (status/readout out).
interface tdc_hw_accum_if;

  logic       start;
  logic [3:0] log2_n;
  logic       rd_next;
  logic       busy;
  logic       done;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;

  modport master (
    output start, log2_n, rd_next,
    input  busy, done, rd_idx, rd_data
  );

  modport slave (
    input  start, log2_n, rd_next,
    output busy, done, rd_idx, rd_data
  );

endinterface

// File: rtl/tdc_sync_edge.sv
// Synchronizer chain plus one-cycle rising-edge pulse for an async strobe.
// Ports: clk, rst_n, i_async (async level), o_pulse (1-cycle pulse).
module tdc_sync_edge #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [N_SYNC-1:0] r_sync;
  logic              r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], i_async};
      r_last <= r_sync[N_SYNC-1];
    end
  end

  assign o_pulse = r_sync[N_SYNC-1] & ~r_last;

endmodule

// File: rtl/tdc_hw_accum.sv
// Batch sum/mean/min/max of TDC popcounts with byte-stepped readout.
// Ports: clk, rst_n, en, hw, hw_val (async strobe), host (slave modport).
module tdc_hw_accum
  import tdc_pkg::*;
#(
  parameter int HW_W         = 7,
  parameter int MAX_LOG2_AVG = 8,
  parameter int N_SYNC       = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [HW_W-1:0] hw,
  input  logic            hw_val,
  tdc_hw_accum_if.slave   host
);

  localparam int         SUM_W = HW_W + MAX_LOG2_AVG;
  localparam int         CNT_W = MAX_LOG2_AVG + 1;
  localparam logic [3:0] L_MAX = 4'(MAX_LOG2_AVG);

  tdc_acc_state_t r_state, w_state_nxt;

  logic [SUM_W-1:0] r_sum, w_sum_nxt;
  logic [HW_W-1:0]  r_min, w_min_nxt;
  logic [HW_W-1:0]  r_max, w_max_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_end;
  logic [3:0]       r_l, w_l_nxt;
  logic [2:0]       r_rd_idx, w_idx_nxt;
  logic [7:0]       r_rd_data, w_word;
  logic [15:0]      w_sum16;
  logic [SUM_W-1:0] w_mean;
  logic             w_samp, w_go, w_acc, w_last;

  tdc_sync_edge #(.N_SYNC(N_SYNC)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (hw_val),
    .o_pulse (w_samp)
  );

  // start always wins over a coincident sample
  assign w_go      = en & host.start;
  assign w_acc     = en & ~host.start & w_samp
                   & (r_state == ACQ);
  assign w_cnt_end = (CNT_W'(1) << r_l) - CNT_W'(1);
  assign w_last    = (r_cnt == w_cnt_end);

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else if (host.start) begin
      w_state_nxt = ACQ;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        ACQ:     if (w_acc && w_last) w_state_nxt = DONE;
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_sum_nxt = r_sum;
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    w_cnt_nxt = r_cnt;
    w_l_nxt   = r_l;
    if (w_go) begin
      w_sum_nxt = '0;
      w_min_nxt = '1;
      w_max_nxt = '0;
      w_cnt_nxt = '0;
      w_l_nxt   = (host.log2_n > L_MAX) ? L_MAX
                                        : host.log2_n;
    end else if (w_acc) begin
      w_sum_nxt = r_sum + SUM_W'(hw);
      w_min_nxt = (hw < r_min) ? hw : r_min;
      w_max_nxt = (hw > r_max) ? hw : r_max;
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // index only advances while staying in DONE
  always_comb begin
    w_idx_nxt = '0;
    if (r_state == DONE && w_state_nxt == DONE) begin
      w_idx_nxt = r_rd_idx;
      if (host.rd_next) begin
        w_idx_nxt = (r_rd_idx == RD_WORDS - 3'd1)
                  ? RD_MEAN : r_rd_idx + 3'd1;
      end
    end
  end

  // built from next-state values so word 0 is ready on DONE entry
  assign w_sum16 = 16'(w_sum_nxt);
  assign w_mean  = w_sum_nxt >> r_l;

  always_comb begin
    w_word = '0;
    unique case (1'b1)
      (w_idx_nxt == RD_MEAN):   w_word = 8'(w_mean);
      (w_idx_nxt == RD_SUM_LO): w_word = w_sum16[7:0];
      (w_idx_nxt == RD_SUM_HI): w_word = w_sum16[15:8];
      (w_idx_nxt == RD_MIN):    w_word = 8'(w_min_nxt);
      (w_idx_nxt == RD_MAX):    w_word = 8'(w_max_nxt);
      default:                  w_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sum     <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_cnt     <= '0;
      r_l       <= '0;
      r_rd_idx  <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sum     <= w_sum_nxt;
      r_min     <= w_min_nxt;
      r_max     <= w_max_nxt;
      r_cnt     <= w_cnt_nxt;
      r_l       <= w_l_nxt;
      r_rd_idx  <= w_idx_nxt;
      r_rd_data <= (w_state_nxt == DONE) ? w_word : '0;
    end
  end

  assign host.busy    = (r_state == ACQ);
  assign host.done    = (r_state == DONE);
  assign host.rd_idx  = r_rd_idx;
  assign host.rd_data = r_rd_data;

endmodule

// File: tb/tb_tdc_hw_accum.sv
// Scoreboard bench for tdc_hw_accum.
// Readout words are queued by stimulus and checked by a monitor.
module tb_tdc_hw_accum;

  localparam int HW_W = 7;
  localparam int MAXL = 8;
  localparam int NS   = 2;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            en     = 1'b0;
  logic [HW_W-1:0] hw     = '0;
  logic            hw_val = 1'b0;

  tdc_hw_accum_if host();

  tdc_hw_accum #(
    .HW_W(HW_W),
    .MAX_LOG2_AVG(MAXL),
    .N_SYNC(NS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .hw(hw),
    .hw_val(hw_val),
    .host(host)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   errs   = 0;
  int   checks = 0;
  logic       p_done = 1'b0;
  logic [2:0] p_idx  = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // a new word is presented on DONE entry and on every index change
  always @(negedge clk) begin
    if (host.done && (!p_done || host.rd_idx != p_idx)) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL rd_unexpected: idx %0d data %0d",
                 host.rd_idx, host.rd_data);
      end else begin
        m_e = q.pop_front();
        if (host.rd_idx !== m_e.idx ||
            host.rd_data !== m_e.data) begin
          errs++;
          $display("FAIL rd_word: got idx %0d data %0d want idx %0d data %0d",
                   host.rd_idx, host.rd_data, m_e.idx, m_e.data);
        end
      end
    end
    p_done = host.done;
    p_idx  = host.rd_idx;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int d);
    exp_t e;
    e.idx  = 3'(i);
    e.data = 8'(d);
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [3:0] l);
    host.log2_n = l;
    host.start  = 1'b1;
    tick();
    host.start  = 1'b0;
  endtask

  task automatic send(input logic [HW_W-1:0] v);
    hw     = v;
    hw_val = 1'b1;
    repeat (NS + 2) tick();
    hw_val = 1'b0;
    repeat (NS + 2) tick();
  endtask

  task automatic step_rd(input int i, input int d);
    push(i, d);
    host.rd_next = 1'b1;
    tick();
    host.rd_next = 1'b0;
    tick();
  endtask

  task automatic read_rest(input int w1, input int w2,
                           input int w3, input int w4,
                           input int w0);
    step_rd(1, w1);
    step_rd(2, w2);
    step_rd(3, w3);
    step_rd(4, w4);
    step_rd(0, w0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    host.start   = 1'b0;
    host.rd_next = 1'b0;
    host.log2_n  = '0;

    #12;
    chk("rst_busy", 32'(host.busy), 0);
    chk("rst_done", 32'(host.done), 0);
    chk("rst_idx", 32'(host.rd_idx), 0);
    chk("rst_data", 32'(host.rd_data), 0);
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // four-sample batch
    push(0, 25);
    pulse_start(4'd2);
    chk("b4_busy", 32'(host.busy), 1);
    send(7'd10);
    send(7'd20);
    send(7'd30);
    chk("b4_done_early", 32'(host.done), 0);
    send(7'd40);
    chk("b4_done", 32'(host.done), 1);
    chk("b4_busy_low", 32'(host.busy), 0);
    read_rest(100, 0, 10, 40, 25);

    // start beats rd_next
    host.log2_n  = 4'd8;
    host.start   = 1'b1;
    host.rd_next = 1'b1;
    tick();
    host.start   = 1'b0;
    host.rd_next = 1'b0;
    chk("prio_busy", 32'(host.busy), 1);
    chk("prio_idx", 32'(host.rd_idx), 0);

    // full 256-sample batch
    push(0, 64);
    repeat (256) send(7'd64);
    chk("full_done", 32'(host.done), 1);
    read_rest(8'h00, 8'h40, 64, 64, 64);

    // clamp of log2_n=12 to 8
    push(0, 3);
    pulse_start(4'd12);
    repeat (255) send(7'd3);
    chk("clamp_done_255", 32'(host.done), 0);
    send(7'd3);
    chk("clamp_done_256", 32'(host.done), 1);
    chk("clamp_busy", 32'(host.busy), 0);
    read_rest(0, 3, 3, 3, 3);

    // single sample and sync latency
    pulse_start(4'd0);
    push(0, 127);
    hw     = 7'd127;
    hw_val = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (host.done) break;
    end
    chk("sync_latency", 32'(n), NS + 1);
    tick();
    hw_val = 1'b0;
    repeat (NS + 2) tick();
    read_rest(127, 0, 127, 127, 127);
    step_rd(1, 127);

    // async reset in DONE
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_done", 32'(host.done), 0);
    chk("arst_idx", 32'(host.rd_idx), 0);
    chk("arst_data", 32'(host.rd_data), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // restart mid-batch, coincident sample dropped
    pulse_start(4'd2);
    send(7'd50);
    send(7'd60);
    hw     = 7'd99;
    hw_val = 1'b1;
    tick();
    tick();
    host.start = 1'b1;
    tick();
    host.start = 1'b0;
    tick();
    hw_val = 1'b0;
    repeat (NS + 2) tick();
    chk("rs_busy", 32'(host.busy), 1);
    host.rd_next = 1'b1;
    tick();
    host.rd_next = 1'b0;
    chk("rs_rdnext_ign", 32'(host.rd_idx), 0);
    push(0, 2);
    send(7'd1);
    send(7'd2);
    send(7'd3);
    chk("rs_done_early", 32'(host.done), 0);
    send(7'd4);
    chk("rs_done", 32'(host.done), 1);
    read_rest(10, 0, 1, 4, 2);

    // enable dropped mid-batch
    pulse_start(4'd2);
    send(7'd5);
    send(7'd6);
    en = 1'b0;
    tick();
    chk("en_busy", 32'(host.busy), 0);
    chk("en_done", 32'(host.done), 0);
    send(7'd7);
    send(7'd8);
    chk("en_done_hold", 32'(host.done), 0);
    en = 1'b1;
    tick();
    chk("en_idle", 32'(host.busy), 0);

    // async reset mid-ACQ
    pulse_start(4'd2);
    send(7'd9);
    chk("ra_busy", 32'(host.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_busy_rst", 32'(host.busy), 0);
    chk("ra_done_rst", 32'(host.done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tdc_hw_accum.md
# tdc_hw_accum

Batch statistics engine for the delay-line TDC. It sits between the TDC core's Hamming-weight output (`hw`/`val_out`) and the tile's output pins. Unlike the current single-shot readout, it accumulates 2^L thermometer-code popcounts per batch and computes sum, mean, min and max. Results are exposed through a byte-wide, host-stepped readout port, so an HW_W-bit code plus statistics fit the 8-bit pin budget.

## Interface
- `HW_W`, default 7: width of `hw` sample (log2(N)+1 for N=64); legal range 1..8.
- `MAX_LOG2_AVG`, default 8: maximum log2 of samples per batch; `HW_W+MAX_LOG2_AVG` must be ≤ 16.
- `N_SYNC`, default 2: synchronizer depth on `hw_val`; legal range ≥ 2.

- `clk` in 1: system clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: tile enable; low forces IDLE.
- `hw` in HW_W: popcount from TDC core; quasi-static, asynchronous to `clk`.
- `hw_val` in 1: sample strobe from TDC core, asynchronous; each rising edge is one new sample.
- `start` in 1: synchronous pulse; begins or restarts a batch.
- `log2_n` in 4: requested log2 of the batch size; values above MAX_LOG2_AVG clamp to MAX_LOG2_AVG.
- `rd_next` in 1: synchronous pulse; advances the readout word.
- `busy` out 1: high in ACQ.
- `done` out 1: high in DONE.
- `rd_idx` out 3: current readout word index.
- `rd_data` out 8: current readout word.

## Operation
- Sample detect: `hw_val` passes through an N_SYNC flop chain, then a rising-edge detect produces `samp` (1 cycle). `hw` is sampled directly on the `samp` cycle.
- States:
  - IDLE: go to ACQ on `start && en`.
  - ACQ: go to DONE when the 2^L-th sample has been accumulated.
  - DONE: go to ACQ on `start`.
  - Any state: `!en` forces IDLE.
- Entering ACQ (from IDLE or from DONE):
  - `sum`=0, `min`=all-ones, `max`=0, `cnt`=0.
  - Latch L = min(`log2_n`, MAX_LOG2_AVG).
- ACQ, on each `samp`:
  - `sum += hw`, zero-extended to SUM_W = HW_W+MAX_LOG2_AVG bits. No overflow is possible.
  - `min = min(min, hw)`, `max = max(max, hw)`, `cnt++`.
  - When `cnt` reaches 2^L−1 before this sample, the next state is DONE.
- Readout words, all zero-extended to 8 bits. `rd_idx` wraps from 4 to 0.
  - 0: mean = `sum >> L`, low 8 bits.
  - 1: `sum[7:0]`.
  - 2: `sum[15:8]`.
  - 3: `min`.
  - 4: `max`.
- Entering DONE sets `rd_idx`=0. Each `rd_next` in DONE increments `rd_idx`.
- Boundary and priority rules:
  - `start` in ACQ restarts the batch and clears the accumulators.
  - A `samp` in the same cycle as `start` is discarded.
  - `start` beats `rd_next`.
  - `rd_next` outside DONE is ignored.
  - `samp` in IDLE or DONE is ignored.
  - L=0 means a one-sample batch; the mean equals the sample.
  - `en` low clears `busy`, `done` and `rd_idx`. Accumulators hold until the next start.
- Reset (async):
  - State=IDLE.
  - `busy`=0, `done`=0, `rd_idx`=0, `rd_data`=0.
  - sync chain=0, `sum`=0, `min`=all-ones, `max`=0, `cnt`=0.

## Timing
- Source requirement (not checked in RTL):
  - `hw_val` high ≥ N_SYNC+2 cycles and low ≥ N_SYNC+2 cycles.
  - `hw` stable from before the `hw_val` rise until the `hw_val` fall.
- Latency from `hw_val` to `samp`:
  - `hw_val` is first sampled high at edge k.
  - `samp` is high in cycle k+N_SYNC−1 (after the N_SYNC-th flop).
  - Accumulators are updated at edge k+N_SYNC.
- Final sample: `busy` falls and `done` rises at the same edge the final sample is accumulated.
- `rd_data` is registered. It holds word 0 in the first DONE cycle.
- `rd_next` in cycle t: `rd_idx` and `rd_data` change at edge t+1.
- `rd_data`=0 whenever the state is not DONE.
- `start` in cycle t: `busy`=1 from edge t+1.

## Structure
- Package `tdc_pkg`:
  - `tdc_acc_state_t` enum {IDLE, ACQ, DONE}.
  - Readout index constants RD_MEAN=0, RD_SUM_LO=1, RD_SUM_HI=2, RD_MIN=3, RD_MAX=4, RD_WORDS=5.
- Sub-module `tdc_sync_edge #(N_SYNC)`: synchronizer chain plus rising-edge pulse. Reused by future asynchronous strobes.

## Test plan
Bench parameters: HW_W=7, MAX_LOG2_AVG=8, N_SYNC=2.
- **Four-sample batch:** `log2_n`=2, samples 10, 20, 30, 40 → `done`=1. Reading with five `rd_next` steps gives 25, 100, 0, 10, 40, then wraps to 25.
- **Full batch:** `log2_n`=8, 256 samples of 64 → mean 64, sum_lo 0x00, sum_hi 0x40, min 64, max 64.
- **Clamp and single sample:**
  - `log2_n`=12 → `done` rises exactly on the 256th sample, not the 255th or 257th.
  - `log2_n`=0 with sample 127 → all words read 127, except sum_hi=0.
- **Restart:** `start` after 2 of 4 samples, then samples 1, 2, 3, 4 → sum 10, mean 2, min 1, max 4. A sample coincident with `start` is not counted.
- **Enable and reset mid-batch:**
  - `en`=0 mid-ACQ → next cycle `busy`=0, `done`=0, no further counting.
  - `rst_n`=0 mid-ACQ → outputs are 0 immediately, without waiting for a clock.
- **Synchronizer timing:** measure `hw_val` rise to accumulator update = N_SYNC cycles. A `hw_val` high for the minimum N_SYNC+2 cycles counts exactly once.
